cu_read_command_arbiter_rr: RTL and testbench
=============================================

Name: cu_read_command_arbiter_rr

Overview:
- Shares the single downstream read command buffer among NUM_REQUESTORS read engine controls. Examples of requesters: the data read engine, graph read engines, prefetchers.
- Each requester pushes CommandBufferLine entries into a private per-lane FIFO.
- A round-robin arbiter pops one command per cycle into a registered output, gated by downstream almost-full.
- Sits between the CU read engines and the CU-level command buffer arbiter.

Parameters:
- NUM_REQUESTORS, 4, number of requester lanes (2..8).
- LANE_FIFO_DEPTH, 8, entries per lane FIFO (power of two, >=4).
- LANE_ALFULL_MARGIN, 3, lane alfull asserted when count >= LANE_FIFO_DEPTH - LANE_ALFULL_MARGIN. This covers the requesters' 2-cycle registered request path.

Ports:
- clock  input  1  core clock.
- rstn  input  1  asynchronous active-low reset.
- enabled_in  input  1  block enable; registered once internally.
- command_in[NUM_REQUESTORS]  input  CommandBufferLine  per-lane command; pushed when .valid=1.
- command_buffer_status_in  input  BufferStatus  downstream buffer status; only .alfull is used.
- lane_status_out[NUM_REQUESTORS]  output  BufferStatus  per-lane FIFO status. Drives .alfull, .full, .empty; all other fields are 0.
- command_out  output  CommandBufferLine  arbitrated command; .valid=1 for exactly one cycle per command.
- grant_out  output  NUM_REQUESTORS  one-hot lane index of command_out; all-zero when command_out.valid=0.
- commands_issued_out  output  32  total commands issued since reset; wraps at 2^32.
- overflow_error_out  output  NUM_REQUESTORS  sticky per-lane flag: push to a full lane was dropped.

Behaviour:

Reset (async, rstn=0):
- All outputs 0, except lane_status_out[i].empty=1.
- FIFOs emptied; round-robin pointer at lane 0.
- enabled register at 0.
- Reset asserted mid-operation discards all queued commands without emitting them.

Enable:
- enabled <= enabled_in each cycle.
- While enabled=0, pushes are ignored, no pops occur, and outputs hold except command_out.valid, which drops to 0 the next cycle.

Input stage:
- command_in[i] is registered (1 cycle).
- A registered entry with .valid=1 is written to FIFO i the following cycle. Push-to-FIFO latency is 1 cycle after sampling.

FIFO push/pop:
- A push is accepted if count_i < LANE_FIFO_DEPTH, or if lane i is popped in the same cycle.
- Otherwise the entry is dropped and overflow_error_out[i] <= 1. It clears only on reset.

Lane status:
- Registered from the post-update count.
- .empty = (count_i == 0).
- .full = (count_i == LANE_FIFO_DEPTH).
- .alfull per LANE_ALFULL_MARGIN.

Arbitration (one decision per cycle):
- Precondition: enabled=1 and command_buffer_status_in.alfull=0.
- Candidate set: lanes with count_i > 0 (FIFO contents only; the input register is not bypassed).
- Search order: starts at lane (last_grant+1) mod NUM_REQUESTORS, wraps, and takes the first non-empty lane.
- On grant: pop that lane's head; last_grant <= granted lane.
- If no lane is non-empty, last_grant is unchanged.

Output register (1 cycle after the pop decision):
- command_out <= popped entry with .valid=1.
- grant_out <= one-hot of the granted lane.
- commands_issued_out increments by 1.
- Otherwise command_out <= 0 (all fields) and grant_out <= 0.
- Command fields (address, size, command, cmd.cu_id, cmd.real_size, abt, ...) pass through unmodified.

Latency and throughput:
- Minimum latency from command_in.valid to command_out.valid is 3 cycles (input reg, FIFO write, pop/output reg).
- Throughput is 1 command per cycle aggregate.

Back-pressure and fairness:
- Downstream alfull stalls pops the same cycle it is sampled. Commands already in the output register are still delivered.
- Fairness: any continuously non-empty lane is granted at least once every NUM_REQUESTORS issuing cycles.

Ordering:
- Per-lane FIFO order is preserved.
- No ordering guarantee across lanes.

Test Plan:
- Single lane: lane 0 pushes 5 commands on consecutive cycles, others idle. command_out emits 5 commands in order, first at cycle 3, back-to-back; grant_out=4'b0001 each; commands_issued_out=5.
- All lanes saturated: lanes 0-3 each push 4 commands at the same time. Grants rotate 0,1,2,3,0,1,2,3,... for 16 cycles; commands_issued_out=16; no overflow.
- Back-pressure: lanes 0 and 1 busy, downstream alfull held high for 10 cycles mid-stream. No new command_out.valid beyond the one already registered. Rotation resumes at the lane following the last grant; no loss.
- Overflow: lane 2 pushes 10 commands while downstream alfull=1 (DEPTH=8). lane_status_out[2].alfull rises at count 5 and .full at count 8. overflow_error_out[2]=1 and 2 commands are dropped. After release, exactly 8 emitted.
- Simultaneous push/pop at full: lane 1 at count 8, popped and pushed in the same cycle. Push accepted, count stays 8, no overflow flag.
- Reset mid-stream: rstn low while 3 lanes hold entries. All outputs 0 immediately (async); empty=1 for all lanes. After release the first grant goes to lane 0 when it has data.

Source files
------------

// File: rtl/cu_read_command_arbiter_rr.sv
// Round-robin arbiter sharing one downstream read command buffer among per-lane command FIFOs.
// Latency: 3 cycles command_in -> command_out; pops stall while downstream alfull is high.
package cu_read_command_arbiter_rr_pkg;

  typedef struct packed {
    logic [7:0] cu_id;
    logic [7:0] real_size;
  } cmd_meta_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] address;
    logic [31:0] size;
    logic [3:0]  command;
    cmd_meta_t   cmd;
    logic [1:0]  abt;
  } command_buffer_line_t;

  typedef struct packed {
    logic valid;
    logic alempty;
    logic empty;
    logic alfull;
    logic full;
  } buffer_status_t;

endpackage

// Generic synchronous FIFO; head is visible combinationally, count includes the head.
// Caller guarantees no push when full unless popping in the same cycle.
module cu_rd_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module cu_read_command_arbiter_rr
  import cu_read_command_arbiter_rr_pkg::*;
#(
  parameter int NUM_REQUESTORS     = 4,
  parameter int LANE_FIFO_DEPTH    = 8,
  parameter int LANE_ALFULL_MARGIN = 3
) (
  input  logic                      clock,
  input  logic                      rstn,
  input  logic                      enabled_in,
  input  command_buffer_line_t      command_in [NUM_REQUESTORS],
  input  buffer_status_t            command_buffer_status_in,
  output buffer_status_t            lane_status_out [NUM_REQUESTORS],
  output command_buffer_line_t      command_out,
  output logic [NUM_REQUESTORS-1:0] grant_out,
  output logic [31:0]               commands_issued_out,
  output logic [NUM_REQUESTORS-1:0] overflow_error_out
);
  localparam int N  = NUM_REQUESTORS;
  localparam int LW = $clog2(N);
  localparam int CW = $clog2(LANE_FIFO_DEPTH) + 1;
  localparam int FW = $bits(command_buffer_line_t);
  localparam logic [CW-1:0] DEPTH_C  = CW'(LANE_FIFO_DEPTH);
  localparam logic [CW-1:0] ALFULL_C = CW'(LANE_FIFO_DEPTH - LANE_ALFULL_MARGIN);
  localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic                 enabled;
  command_buffer_line_t in_reg [N];
  logic [FW-1:0]        head_dat [N];
  logic [CW-1:0]        count [N];
  logic [CW-1:0]        count_next [N];
  logic [N-1:0]         push;
  logic [N-1:0]         pop;
  logic [N-1:0]         drop;
  logic                 grant_vld;
  logic [LW-1:0]        grant_idx;
  logic [LW-1:0]        rr_ptr;
  logic                 unused_status;

  // Only alfull of the downstream status drives behaviour.
  assign unused_status = ^{command_buffer_status_in.valid, command_buffer_status_in.alempty,
                           command_buffer_status_in.empty, command_buffer_status_in.full};

  function automatic buffer_status_t lane_status(input logic [CW-1:0] c);
    buffer_status_t s;
    s        = '0;
    s.empty  = (c == '0);
    s.full   = (c == DEPTH_C);
    s.alfull = (c >= ALFULL_C);
    return s;
  endfunction

  // rr_ptr holds the first lane to search, i.e. last grant + 1.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (enabled && !command_buffer_status_in.alfull) begin
      for (int k = 0; k < N; k++) begin
        if (!grant_vld && count[LW'((int'(rr_ptr) + k) % N)] != '0) begin
          grant_vld = 1'b1;
          grant_idx = LW'((int'(rr_ptr) + k) % N);
        end
      end
    end
  end

  // A full lane still accepts a push in the cycle its head is popped.
  always_comb begin
    push = '0;
    pop  = '0;
    drop = '0;
    for (int i = 0; i < N; i++) begin
      pop[i]        = grant_vld && (grant_idx == LW'(i));
      push[i]       = enabled && in_reg[i].valid && (count[i] < DEPTH_C || pop[i]);
      drop[i]       = enabled && in_reg[i].valid && !push[i];
      count_next[i] = count[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    cu_rd_arb_fifo #(
      .WIDTH (FW),
      .DEPTH (LANE_FIFO_DEPTH)
    ) u_fifo (
      .clock    (clock),
      .rstn     (rstn),
      .push     (push[g]),
      .push_dat (in_reg[g]),
      .pop      (pop[g]),
      .head_dat (head_dat[g]),
      .count    (count[g])
    );
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled             <= 1'b0;
      rr_ptr              <= '0;
      command_out         <= '0;
      grant_out           <= '0;
      commands_issued_out <= '0;
      overflow_error_out  <= '0;
      for (int i = 0; i < N; i++) begin
        in_reg[i]          <= '0;
        lane_status_out[i] <= lane_status('0);
      end
    end else begin
      enabled            <= enabled_in;
      overflow_error_out <= overflow_error_out | drop;
      for (int i = 0; i < N; i++) begin
        in_reg[i]          <= command_in[i];
        lane_status_out[i] <= lane_status(count_next[i]);
      end
      if (grant_vld) begin
        // Stored entries always carry valid=1, so the head passes through as-is.
        command_out         <= command_buffer_line_t'(head_dat[grant_idx]);
        grant_out           <= ONE_HOT0 << grant_idx;
        commands_issued_out <= commands_issued_out + 32'd1;
        rr_ptr              <= (grant_idx == LW'(N - 1)) ? '0 : grant_idx + LW'(1);
      end else if (!enabled) begin
        command_out.valid <= 1'b0;
        grant_out         <= '0;
      end else begin
        command_out <= '0;
        grant_out   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_cu_read_command_arbiter_rr.sv
// Bench for cu_read_command_arbiter_rr: directed scenarios plus random traffic,
// scored against a queue-based lane model.
module tb_cu_read_command_arbiter_rr;
  import cu_read_command_arbiter_rr_pkg::*;

  localparam int N = 4;
  localparam int D = 8;
  localparam int M = 3;

  typedef struct packed {
    command_buffer_line_t line;
    logic [7:0]           lane;
    logic [31:0]          seq;
  } exp_t;

  logic                 clock = 1'b0;
  logic                 rstn;
  logic                 enabled_in;
  command_buffer_line_t cmd_in [N];
  buffer_status_t       ds_status;
  buffer_status_t       lane_status [N];
  command_buffer_line_t command_out;
  logic [N-1:0]         grant_out;
  logic [31:0]          issued;
  logic [N-1:0]         ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per lane plus the input and enable registers.
  command_buffer_line_t mq [N][$];
  command_buffer_line_t m_in [N];
  logic                 m_en;
  int                   m_ptr;
  logic [N-1:0]         m_ovf;
  logic [31:0]          m_issued;
  exp_t                 exp_q [$];

  always #5 clock = ~clock;

  cu_read_command_arbiter_rr #(
    .NUM_REQUESTORS     (N),
    .LANE_FIFO_DEPTH    (D),
    .LANE_ALFULL_MARGIN (M)
  ) dut (
    .clock                    (clock),
    .rstn                     (rstn),
    .enabled_in               (enabled_in),
    .command_in               (cmd_in),
    .command_buffer_status_in (ds_status),
    .lane_status_out          (lane_status),
    .command_out              (command_out),
    .grant_out                (grant_out),
    .commands_issued_out      (issued),
    .overflow_error_out       (ovf)
  );

  function automatic buffer_status_t exp_st(input int n);
    buffer_status_t s;
    s        = '0;
    s.empty  = (n == 0);
    s.full   = (n == D);
    s.alfull = (n >= D - M);
    return s;
  endfunction

  function automatic command_buffer_line_t mk();
    command_buffer_line_t l;
    l               = '0;
    l.valid         = 1'b1;
    l.address       = {$urandom, $urandom};
    l.size          = $urandom;
    l.command       = 4'($urandom);
    l.cmd.cu_id     = 8'($urandom);
    l.cmd.real_size = 8'($urandom);
    l.abt           = 2'($urandom);
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      m_in[i] = '0;
    end
    m_en     = 1'b0;
    m_ptr    = 0;
    m_ovf    = '0;
    m_issued = '0;
    exp_q.delete();
  endtask

  // Predicts the effect of the coming rising edge given the inputs now driven.
  task automatic step();
    int g;
    g = -1;
    if (m_en && !ds_status.alfull)
      for (int k = 0; k < N; k++)
        if (g < 0 && mq[(m_ptr + k) % N].size() > 0) g = (m_ptr + k) % N;
    if (m_en)
      for (int i = 0; i < N; i++)
        if (m_in[i].valid) begin
          if (mq[i].size() < D || g == i) mq[i].push_back(m_in[i]);
          else m_ovf[i] = 1'b1;
        end
    if (g >= 0) begin
      exp_t e;
      e.line   = mq[g].pop_front();
      e.lane   = 8'(g);
      m_issued = m_issued + 32'd1;
      e.seq    = m_issued;
      exp_q.push_back(e);
      m_ptr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) m_in[i] = cmd_in[i];
    m_en = enabled_in;
  endtask

  task automatic check_status();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (lane_status[i] !== exp_st(mq[i].size())) begin
        errors++;
        $display("FAIL lane_status[%0d] @%0t: got %b want %b", i, $time, lane_status[i],
                 exp_st(mq[i].size()));
      end
    end
    checks++;
    if (ovf !== m_ovf) begin
      errors++;
      $display("FAIL overflow_error @%0t: got %b want %b", $time, ovf, m_ovf);
    end
  endtask

  task automatic tick();
    step();
    @(negedge clock);
    check_status();
  endtask

  task automatic drive(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) cmd_in[i] = mask[i] ? mk() : '0;
  endtask

  task automatic idle(input int n);
    drive('0);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    drive('0);
    #1;
    checks++;
    if (command_out !== '0 || grant_out !== '0 || issued !== '0 || ovf !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b grant=%b issued=%0d ovf=%b want all 0",
               command_out.valid, grant_out, issued, ovf);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (lane_status[i] !== exp_st(0)) begin
        errors++;
        $display("FAIL reset_lane_status[%0d]: got %b want %b", i, lane_status[i], exp_st(0));
      end
    end
    model_reset();
    repeat (3) @(negedge clock);
    rstn = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a command.
  initial begin
    forever begin
      @(negedge clock);
      if (rstn === 1'b1) begin
        if (command_out.valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_cmd @%0t: got grant=%b, want no command", $time, grant_out);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (command_out !== e.line || grant_out !== (N'(1) << e.lane) || issued !== e.seq) begin
              errors++;
              $display("FAIL cmd_out @%0t: got grant=%b issued=%0d addr=%h want grant=%b issued=%0d addr=%h",
                       $time, grant_out, issued, command_out.address, N'(1) << e.lane, e.seq,
                       e.line.address);
            end
          end
        end else begin
          checks++;
          if (grant_out !== '0) begin
            errors++;
            $display("FAIL idle_grant @%0t: got %b want 0", $time, grant_out);
          end
        end
      end
    end
  end

  initial begin
    rstn       = 1'b0;
    enabled_in = 1'b1;
    ds_status  = '0;
    drive('0);
    model_reset();
    repeat (3) @(negedge clock);
    rstn = 1'b1;
    idle(2);

    // Single lane, back-to-back.
    for (int k = 0; k < 5; k++) begin drive(4'b0001); tick(); end
    idle(8);

    // All lanes saturated.
    for (int k = 0; k < 4; k++) begin drive(4'b1111); tick(); end
    idle(20);

    // Back-pressure mid-stream on two busy lanes.
    for (int k = 0; k < 16; k++) begin
      ds_status.alfull = (k >= 4 && k < 14);
      drive(4'b0011);
      tick();
    end
    ds_status.alfull = 1'b0;
    idle(15);

    // Overflow of lane 2 while downstream is blocked.
    ds_status.alfull = 1'b1;
    for (int k = 0; k < 10; k++) begin drive(4'b0100); tick(); end
    idle(3);
    checks++;
    if (ovf[2] !== 1'b1) begin
      errors++;
      $display("FAIL lane2_overflow: got %b want 1", ovf[2]);
    end
    ds_status.alfull = 1'b0;
    idle(15);

    // Lane 1 at full, popped and pushed in the same cycle.
    for (int k = 0; k < 12; k++) begin
      ds_status.alfull = (k <= 8);
      drive(4'b0010);
      tick();
    end
    ds_status.alfull = 1'b0;
    idle(15);

    // Random traffic with back-pressure and enable toggling.
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] mask;
      for (int i = 0; i < N; i++) mask[i] = ($urandom_range(0, 9) < 3);
      ds_status.alfull = ($urandom_range(0, 4) == 0);
      enabled_in       = ($urandom_range(0, 19) != 0);
      drive(mask);
      tick();
    end
    enabled_in       = 1'b1;
    ds_status.alfull = 1'b0;
    idle(40);

    // Reset while three lanes hold entries; restart from lane 0.
    ds_status.alfull = 1'b1;
    for (int k = 0; k < 3; k++) begin drive(4'b1110); tick(); end
    idle(2);
    do_reset();
    ds_status.alfull = 1'b0;
    idle(2);
    drive(4'b0101);
    tick();
    idle(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d commands outstanding want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
